i2c_ball_rx_slave: RTL and testbench

//  I2C target (write-only) on the receiving player's board. Accepts the ball-transfer packet sent by the

---
 rtl/i2c_ball_rx_slave_if.sv | 25 ++
 rtl/i2c_ball_rx_slave.sv | 211 +++++++++++++++++++++
 tb/tb_i2c_ball_rx_slave.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_ball_rx_slave_if.sv
// Bus bundle for the ball-transfer I2C target: pad-side I2C lines plus the
// register/status view presented to the game controller.
interface i2c_ball_rx_slave_if;
  logic       i_scl;
  logic       i_sda;
  logic       o_sda_oe;
  logic [7:0] o_reg0, o_reg1, o_reg2, o_reg3, o_reg4, o_reg5;
  logic       o_pkt_valid;
  logic       o_slave_done;
  logic       i_done_clr;
  logic       o_busy;
  logic       o_pkt_err;

  modport slave (
    input  i_scl, i_sda, i_done_clr,
    output o_sda_oe, o_reg0, o_reg1, o_reg2, o_reg3, o_reg4, o_reg5,
           o_pkt_valid, o_slave_done, o_busy, o_pkt_err
  );

  modport master (
    output i_scl, i_sda, i_done_clr,
    input  o_sda_oe, o_reg0, o_reg1, o_reg2, o_reg3, o_reg4, o_reg5,
           o_pkt_valid, o_slave_done, o_busy, o_pkt_err
  );
endinterface

// File: rtl/i2c_ball_rx_slave.sv
// Write-only I2C target receiving the ball packet into six registers, committed atomically on STOP.
// Optional feature: I2C_SLV_CHECKSUM_EN appends an XOR checksum byte to the packet.

// Per-line input conditioning: 2-FF synchroniser then a run-length glitch filter.
module i2c_ball_rx_filt #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filt
);
  logic [1:0]          sync;
  logic [FILT_LEN-1:0] hist;

  // Reset to the idle-bus level so no START/STOP is seen coming out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync <= '1;
      hist <= '1;
      filt <= 1'b1;
    end else begin
      sync <= {sync[0], raw};
      hist <= {hist[FILT_LEN-2:0], sync[1]};
      if (&hist)       filt <= 1'b1;
      else if (~|hist) filt <= 1'b0;
    end
  end
endmodule

module i2c_ball_rx_slave #(
  parameter logic [6:0] SLV_ADDR  = 7'h2A,
  parameter int         NUM_BYTES = 6,
  parameter int         FILT_LEN  = 3
) (
  input logic                 clk,
  input logic                 reset,
  i2c_ball_rx_slave_if.slave  bus
);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ADDR     = 3'd1;
  localparam logic [2:0] ADDR_ACK = 3'd2;
  localparam logic [2:0] DATA     = 3'd3;
  localparam logic [2:0] DATA_ACK = 3'd4;
  localparam logic [2:0] IGNORE   = 3'd5;

`ifdef I2C_SLV_CHECKSUM_EN
  localparam int NB = NUM_BYTES + 1;
`else
  localparam int NB = NUM_BYTES;
`endif
  localparam int             IW   = $clog2(NB + 1);
  localparam logic [IW-1:0]  NB_W = IW'(NB);

  logic [1:0] raw_v, filt_v;
  logic       scl_f, sda_f, scl_q, sda_q;
  logic       scl_rise, scl_fall, start_det, stop_det;

  assign raw_v = {bus.i_scl, bus.i_sda};

  i2c_ball_rx_filt #(.FILT_LEN(FILT_LEN)) u_filt [1:0] (
    .clk  (clk),
    .reset(reset),
    .raw  (raw_v),
    .filt (filt_v)
  );

  assign scl_f     = filt_v[1];
  assign sda_f     = filt_v[0];
  assign scl_rise  = scl_f & ~scl_q;
  assign scl_fall  = ~scl_f & scl_q;
  assign start_det = scl_f & scl_q & sda_q & ~sda_f;
  assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;

  logic [2:0]                 state;
  logic [2:0]                 bit_cnt;
  logic [7:0]                 sh;
  logic [7:0]                 byte_in;
  logic [IW-1:0]              idx;
  logic                       ovf, matched, ack, ninth;
  logic [NB-1:0][7:0]         shadow;
  logic [NUM_BYTES-1:0][7:0]  rg;
  logic                       sda_oe, pkt_valid, pkt_err, done, busy;
  logic                       csum_ok, pkt_good, commit;

  assign byte_in = {sh[6:0], sda_f};

`ifdef I2C_SLV_CHECKSUM_EN
  logic [7:0] csum_x;
  always_comb begin
    csum_x = '0;
    for (int i = 0; i < NUM_BYTES; i++) csum_x = csum_x ^ shadow[i];
  end
  assign csum_ok = (csum_x == shadow[NUM_BYTES]);
`else
  assign csum_ok = 1'b1;
`endif

  assign pkt_good = (idx == NB_W) & ~ovf & csum_ok;
  assign commit   = stop_det & matched & pkt_good;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
      state     <= IDLE;
      bit_cnt   <= '0;
      sh        <= '0;
      idx       <= '0;
      ovf       <= 1'b0;
      matched   <= 1'b0;
      ack       <= 1'b0;
      ninth     <= 1'b0;
      shadow    <= '0;
      rg        <= '0;
      sda_oe    <= 1'b0;
      pkt_valid <= 1'b0;
      pkt_err   <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      scl_q     <= scl_f;
      sda_q     <= sda_f;
      pkt_valid <= 1'b0;
      pkt_err   <= 1'b0;
      // A new packet outranks a clear arriving in the same cycle.
      if (commit)              done <= 1'b1;
      else if (bus.i_done_clr) done <= 1'b0;

      if (start_det) begin
        // Repeated START silently drops whatever was collected so far.
        state   <= ADDR;
        busy    <= 1'b1;
        bit_cnt <= '0;
        idx     <= '0;
        ovf     <= 1'b0;
        matched <= 1'b0;
        ninth   <= 1'b0;
        sda_oe  <= 1'b0;
      end else if (stop_det) begin
        state   <= IDLE;
        busy    <= 1'b0;
        bit_cnt <= '0;
        idx     <= '0;
        ovf     <= 1'b0;
        matched <= 1'b0;
        ninth   <= 1'b0;
        sda_oe  <= 1'b0;
        if (matched) begin
          if (pkt_good) begin
            rg        <= shadow[NUM_BYTES-1:0];
            pkt_valid <= 1'b1;
          end else begin
            pkt_err <= 1'b1;
          end
        end
      end else begin
        case (state)
          ADDR: if (scl_rise) begin
            sh      <= byte_in;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              ack     <= (byte_in == {SLV_ADDR, 1'b0});
              matched <= (byte_in == {SLV_ADDR, 1'b0});
              state   <= ADDR_ACK;
            end
          end
          DATA: if (scl_rise) begin
            sh      <= byte_in;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= DATA_ACK;
              if (idx < NB_W) begin
                shadow[idx] <= byte_in;
                idx         <= idx + 1'b1;
                ack         <= 1'b1;
              end else begin
                ovf <= 1'b1;
                ack <= 1'b0;
              end
            end
          end
          // First falling edge ends bit 8 and drives ACK; the next one ends the 9th clock.
          ADDR_ACK, DATA_ACK: if (scl_fall) begin
            if (!ninth) begin
              sda_oe <= ack;
              ninth  <= 1'b1;
            end else begin
              sda_oe <= 1'b0;
              ninth  <= 1'b0;
              state  <= (state == ADDR_ACK && !ack) ? IGNORE : DATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.o_sda_oe     = sda_oe;
  assign bus.o_reg0       = rg[0];
  assign bus.o_reg1       = rg[1];
  assign bus.o_reg2       = rg[2];
  assign bus.o_reg3       = rg[3];
  assign bus.o_reg4       = rg[4];
  assign bus.o_reg5       = rg[5];
  assign bus.o_pkt_valid  = pkt_valid;
  assign bus.o_slave_done = done;
  assign bus.o_busy       = busy;
  assign bus.o_pkt_err    = pkt_err;
endmodule

// File: tb/tb_i2c_ball_rx_slave.sv
// Directed bench for i2c_ball_rx_slave: bit-banged I2C master, scoreboard of expected packet/error events.
module tb_i2c_ball_rx_slave;
  localparam int Q = 8;  // clk cycles per quarter SCL period

  typedef struct {
    logic        is_err;
    logic [47:0] regs;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  logic done_clr = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   oe_cnt = 0;
  exp_t sbq[$];
  logic [47:0] exp_regs = '0;

  i2c_ball_rx_slave_if bus();

  assign bus.i_scl      = m_scl;
  assign bus.i_sda      = m_sda & ~bus.o_sda_oe;
  assign bus.i_done_clr = done_clr;

  i2c_ball_rx_slave dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] get_regs();
    return {bus.o_reg0, bus.o_reg1, bus.o_reg2, bus.o_reg3, bus.o_reg4, bus.o_reg5};
  endfunction

  function automatic logic [7:0] xor8(input logic [47:0] p);
    logic [7:0] x;
    x = '0;
    for (int i = 0; i < 6; i++) x = x ^ p[47-8*i -: 8];
    return x;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic sb_push(input logic is_err, input logic [47:0] regs);
    exp_t e;
    e.is_err = is_err;
    e.regs   = regs;
    sbq.push_back(e);
    exp_regs = regs;
  endtask

  // Scoreboard side: every pkt_valid / pkt_err pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (bus.o_sda_oe) oe_cnt++;
    if (reset && (bus.o_pkt_valid || bus.o_pkt_err)) begin
      if (sbq.size() == 0) begin
        chk("unexpected_event", {62'd0, bus.o_pkt_valid, bus.o_pkt_err}, 64'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("event_kind", {62'd0, bus.o_pkt_valid, bus.o_pkt_err}, {62'd0, ~e.is_err, e.is_err});
        chk("event_regs", {16'd0, get_regs()}, {16'd0, e.regs});
      end
    end
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wait_q();
    m_scl = 1'b1; wait_q();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b1; wait_q();
    m_sda = 1'b1; wait_q(); wait_q();
  endtask

  task automatic clk_bit(input logic v, input bit glitch);
    m_sda = v; wait_q();
    if (glitch) begin
      m_scl = 1'b1; @(negedge clk);
      m_scl = 1'b0; wait_q();
    end
    m_scl = 1'b1; wait_q(); wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit glitch, output logic ack);
    for (int i = 7; i >= 0; i--) clk_bit(b[i], glitch && (i == 4));
    m_sda = 1'b1; wait_q();
    m_scl = 1'b1; wait_q();
    ack = ~bus.i_sda;
    wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  // START, address, full payload (plus checksum when enabled); the caller ends it with a STOP.
  task automatic full_pkt(input logic [47:0] p, input bit glitch);
    logic a;
    i2c_start();
    send_byte(8'h54, 1'b0, a);
    chk("addr_ack", a, 1);
    for (int i = 0; i < 6; i++) begin
      send_byte(p[47-8*i -: 8], glitch, a);
      chk("data_ack", a, 1);
    end
`ifdef I2C_SLV_CHECKSUM_EN
    send_byte(xor8(p), glitch, a);
    chk("csum_ack", a, 1);
`endif
    chk("busy_mid", bus.o_busy, 1);
    sb_push(1'b0, p);
  endtask

  initial begin
    logic        a;
    logic        seen;
    int          oe_snap;
    logic [47:0] pa, pb, pc, pd;
    pa = 48'h10_20_03_01_05_00;
    pb = 48'hA1_B2_C3_D4_E5_F6;
    pc = 48'h5A_00_FF_7E_81_3C;
    pd = 48'h01_23_45_67_89_AB;

    // Reset state
    repeat (4) @(negedge clk);
    chk("rst_regs", get_regs(), 0);
    chk("rst_oe", bus.o_sda_oe, 0);
    chk("rst_flags", {bus.o_pkt_valid, bus.o_slave_done, bus.o_busy, bus.o_pkt_err}, 0);
    reset = 1'b1;
    wait_q();

    // Full packet
    full_pkt(pa, 1'b0);
    i2c_stop();
    chk("t1_done", bus.o_slave_done, 1);
    chk("t1_busy", bus.o_busy, 0);
    chk("t1_drain", sbq.size(), 0);

    // Wrong address (0x2B): NACK, no drive, then ignored traffic
    oe_snap = oe_cnt;
    i2c_start();
    send_byte(8'h56, 1'b0, a);
    chk("t2_addr_nack", a, 0);
    send_byte(8'h77, 1'b0, a);
    chk("t2_ignore_nack", a, 0);
    chk("t2_busy_mid", bus.o_busy, 1);
    i2c_stop();
    chk("t2_oe_quiet", oe_cnt - oe_snap, 0);
    chk("t2_busy", bus.o_busy, 0);
    chk("t2_regs", get_regs(), exp_regs);
    chk("t2_done", bus.o_slave_done, 1);

    // Short packet
    i2c_start();
    send_byte(8'h54, 1'b0, a);
    for (int i = 0; i < 3; i++) begin
      send_byte(8'hC0 + 8'(i), 1'b0, a);
      chk("t3_ack", a, 1);
    end
    sb_push(1'b1, exp_regs);
    i2c_stop();
    chk("t3_drain", sbq.size(), 0);
    chk("t3_done_kept", bus.o_slave_done, 1);
    done_clr = 1'b1; @(negedge clk); done_clr = 1'b0; @(negedge clk);
    chk("t3_done_clr", bus.o_slave_done, 0);

    // Two bytes, repeated START, full packet; clear held through STOP to test set priority
    i2c_start();
    send_byte(8'h54, 1'b0, a);
    send_byte(8'hEE, 1'b0, a);
    send_byte(8'hDD, 1'b0, a);
    full_pkt(pb, 1'b0);
    done_clr = 1'b1;
    m_sda = 1'b0; wait_q();
    m_scl = 1'b1; wait_q();
    m_sda = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (bus.o_pkt_valid) begin
        seen = 1'b1;
        done_clr = 1'b0;
        chk("t4_set_wins", bus.o_slave_done, 1);
      end
    end
    done_clr = 1'b0;
    chk("t4_pv_seen", seen, 1);
    wait_q();
    chk("t4_done_hold", bus.o_slave_done, 1);
    chk("t4_drain", sbq.size(), 0);

    // Asynchronous reset in the middle of byte 4
    i2c_start();
    send_byte(8'h54, 1'b0, a);
    for (int i = 0; i < 3; i++) send_byte(8'h33, 1'b0, a);
    for (int i = 0; i < 4; i++) clk_bit(1'b1, 1'b0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t5_rst_regs", get_regs(), 0);
    chk("t5_rst_flags", {bus.o_sda_oe, bus.o_pkt_valid, bus.o_slave_done, bus.o_busy, bus.o_pkt_err}, 0);
    exp_regs = '0;
    m_scl = 1'b1; m_sda = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    wait_q();
    full_pkt(pc, 1'b0);
    i2c_stop();
    chk("t5_drain", sbq.size(), 0);
    chk("t5_done", bus.o_slave_done, 1);

    // 1-clk SCL glitch inside every data byte
    full_pkt(pd, 1'b1);
    i2c_stop();
    chk("t6_drain", sbq.size(), 0);

`ifdef I2C_SLV_CHECKSUM_EN
    // Bad checksum byte is ACKed but the packet is rejected
    i2c_start();
    send_byte(8'h54, 1'b0, a);
    for (int i = 0; i < 6; i++) send_byte(8'h40 + 8'(i), 1'b0, a);
    send_byte(xor8(48'h40_41_42_43_44_45) ^ 8'h01, 1'b0, a);
    chk("t7_bad_csum_ack", a, 1);
`else
    // Seventh byte overflows and is NACKed
    i2c_start();
    send_byte(8'h54, 1'b0, a);
    for (int i = 0; i < 6; i++) send_byte(8'h40 + 8'(i), 1'b0, a);
    send_byte(8'h99, 1'b0, a);
    chk("t7_ovf_nack", a, 0);
`endif
    sb_push(1'b1, exp_regs);
    i2c_stop();
    chk("t7_drain", sbq.size(), 0);
    chk("t7_regs", get_regs(), pd);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
